// File: rtl/shape_asm_pkg.sv
// shape_assembler shared types: FSM states, element type and shape record.
// Imported by the interface and the assembler top.
package shape_asm_pkg;

    localparam int ELEM_W_DEF    = 39;
    localparam int ARRAY_LEN_DEF = 4;

    typedef enum logic [1:0] {
        FILL,
        OUT,
        DRAIN
    } shape_asm_state_e;

    typedef logic [ELEM_W_DEF-1:0] shape_elem_t;

    // Shape record consumed by the area stage; array1[0] is the first word.
    typedef struct packed {
        logic [7:0]                         shape_kind;
        logic [15:0]                        tag;
        shape_elem_t [ARRAY_LEN_DEF-1:0]    array1;
    } shape_t;

endpackage

// File: rtl/shape_if.sv
// Valid/ready carrier for one shape record.
// Source drives valid/data, Sink drives ready.
interface IShapeType_ValidReady;
    import shape_asm_pkg::*;

    logic   valid;
    logic   ready;
    shape_t data;

    modport Source (output valid, output data, input ready);
    modport Sink   (input valid, input data, output ready);

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for malformed-message statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Count up on inc, stop at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shape_assembler.sv
// Packs a serial element stream into shape records, repairing bad lengths.
// Optional macro SHAPE_ASM_DOUBLE_BUF_EN adds a second output record register.
module shape_assembler
    import shape_asm_pkg::*;
#(
    parameter int ELEM_W    = ELEM_W_DEF,
    parameter int ARRAY_LEN = ARRAY_LEN_DEF,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ELEM_W-1:0]         in_data,
    input  logic                      in_last,
    IShapeType_ValidReady.Source      shapeOut,
    output logic [CNT_W-1:0]          short_cnt,
    output logic [CNT_W-1:0]          long_cnt
);

    localparam int IDX_W = (ARRAY_LEN > 1) ? $clog2(ARRAY_LEN) : 1;

    typedef logic [ARRAY_LEN-1:0][ELEM_W-1:0] rec_t;

    shape_asm_state_e state;
    logic [IDX_W-1:0] idx;
    rec_t             rec;
    rec_t             out_rec;
    logic             out_valid;
    shape_t           shape_data;

    logic accept;
    logic at_end;
    logic fill_acc;
    logic short_inc;
    logic long_inc;

    // in_ready is a pure state decode, independent of shapeOut.ready
    assign in_ready  = (state != OUT);
    assign accept    = in_valid && in_ready;
    assign at_end    = (idx == IDX_W'(ARRAY_LEN - 1));
    assign fill_acc  = accept && (state == FILL);
    assign short_inc = fill_acc && in_last && !at_end;
    assign long_inc  = fill_acc && at_end && !in_last;

`ifdef SHAPE_ASM_DOUBLE_BUF_EN

    rec_t rec_next;
    rec_t load_data;
    logic free;
    logic load;

    // Record contents including the word being accepted this cycle
    always_comb begin
        rec_next      = rec;
        rec_next[idx] = in_data;
    end

    assign free = !out_valid || shapeOut.ready;

    // Decide when a finished record moves into the output register
    always_comb begin
        load      = 1'b0;
        load_data = rec;
        unique case (state)
            FILL: begin
                if (fill_acc && in_last && free) begin
                    load      = 1'b1;
                    load_data = rec_next;
                end
            end
            DRAIN: begin
                if (accept && in_last && free) begin
                    load = 1'b1;
                end
            end
            OUT: begin
                if (free) begin
                    load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Assembly FSM; stalls in OUT only while the output register is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            idx   <= '0;
            rec   <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        if (in_last && load) begin
                            rec <= '0;
                            idx <= '0;
                        end else begin
                            rec[idx] <= in_data;
                            if (in_last) begin
                                state <= OUT;
                            end else if (at_end) begin
                                state <= DRAIN;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (accept && in_last) begin
                        if (load) begin
                            rec   <= '0;
                            idx   <= '0;
                            state <= FILL;
                        end else begin
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (load) begin
                        rec   <= '0;
                        idx   <= '0;
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Output record register with valid held until handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rec   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_rec   <= load_data;
        end else if (shapeOut.ready) begin
            out_valid <= 1'b0;
        end
    end

`else

    // Assembly FSM; the fill buffer doubles as the output record
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            rec       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        rec[idx] <= in_data;
                        if (in_last) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                        end else if (at_end) begin
                            state <= DRAIN;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (accept && in_last) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (shapeOut.ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        idx       <= '0;
                        rec       <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign out_rec = rec;

`endif

    // Shape record: only array1 carries data, other fields tied to 0
    always_comb begin
        shape_data        = '0;
        shape_data.array1 = out_rec;
    end

    assign shapeOut.valid = out_valid;
    assign shapeOut.data  = shape_data;

    sat_counter #(.CNT_W(CNT_W)) u_short_cnt (
        .clk (clk),
        .rst (rst),
        .inc (short_inc),
        .cnt (short_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_long_cnt (
        .clk (clk),
        .rst (rst),
        .inc (long_inc),
        .cnt (long_cnt)
    );

endmodule

// File: tb/tb_shape_assembler.sv
// Scoreboard bench for shape_assembler (default single-buffer build).
// Counters built 2 bits wide so saturation is reachable.
module tb_shape_assembler;
    import shape_asm_pkg::*;

    localparam int EW = 39;
    localparam int AL = 4;
    localparam int CW = 2;

    typedef logic [AL-1:0][EW-1:0] rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [EW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic [CW-1:0] short_cnt;
    logic [CW-1:0] long_cnt;

    IShapeType_ValidReady so ();

    rec_t          exp_q[$];
    rec_t          got_q[$];
    logic [EW-1:0] msg_q[$];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    shape_assembler #(
        .ELEM_W    (EW),
        .ARRAY_LEN (AL),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .shapeOut  (so),
        .short_cnt (short_cnt),
        .long_cnt  (long_cnt)
    );

    // Capture every output handshake, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && so.valid && so.ready) begin
            got_q.push_back(so.data.array1);
        end
    end

    task automatic send_word(input logic [EW-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_accept: in_ready=%0b after %0d cycles, want 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg();
        rec_t e = '0;
        int   n = msg_q.size();
        for (int i = 0; i < n; i++) begin
            if (i < AL) e[i] = msg_q[i];
        end
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            send_word(msg_q[i], (i == n - 1));
        end
    endtask

    task automatic expect_rec(input string name);
        int   n = 0;
        rec_t g;
        rec_t e = '0;
        while (got_q.size() == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (got_q.size() == 0) begin
            bad++;
            $display("FAIL %s: no record after %0d cycles, want %0h", name, n, e);
        end else begin
            g = got_q.pop_front();
            if (g !== e) begin
                bad++;
                $display("FAIL %s: got %0h want %0h", name, g, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        so.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready: got %0b want 1", in_ready);
        end
        total++;
        if (so.valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_valid: got %0b want 0", so.valid);
        end
        total++;
        if (so.data !== '0) begin
            bad++;
            $display("FAIL rst_data: got %0h want 0", so.data);
        end
        total++;
        if (short_cnt !== 2'd0 || long_cnt !== 2'd0) begin
            bad++;
            $display("FAIL rst_cnt: got %0d/%0d want 0/0", short_cnt, long_cnt);
        end
    endtask

    task automatic test_exact();
        msg_q = '{39'hDEADBEEF, 39'd1, 39'd2, 39'd3};
        send_msg();
        total++;
        if (so.valid !== 1'b1) begin
            bad++;
            $display("FAIL exact_latency: valid=%0b want 1", so.valid);
        end
`ifndef SHAPE_ASM_DOUBLE_BUF_EN
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL exact_in_ready: got %0b want 0", in_ready);
        end
`endif
        expect_rec("exact_rec");
        total++;
        if (short_cnt !== 2'd0 || long_cnt !== 2'd0) begin
            bad++;
            $display("FAIL exact_cnt: got %0d/%0d want 0/0", short_cnt, long_cnt);
        end
    endtask

    task automatic test_backpressure();
        so.ready = 1'b0;
        msg_q = '{39'h11, 39'h22, 39'h33, 39'h7F_FFFF_FFFF};
        send_msg();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (so.valid !== 1'b1 || so.data.array1 !== exp_q[0]) begin
                bad++;
                $display("FAIL bp_hold%0d: valid=%0b data=%0h want 1/%0h",
                         i, so.valid, so.data.array1, exp_q[0]);
            end
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_in_ready%0d: got %0b want 0", i, in_ready);
            end
            total++;
            if (so.data.shape_kind !== 8'd0 || so.data.tag !== 16'd0) begin
                bad++;
                $display("FAIL bp_fields: kind=%0h tag=%0h want 0/0",
                         so.data.shape_kind, so.data.tag);
            end
        end
        @(posedge clk);
        #1;
        so.ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || so.valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%0b valid=%0b want 1/0", in_ready, so.valid);
        end
        expect_rec("bp_rec");
    endtask

    task automatic test_early_last();
        msg_q = '{39'h0A, 39'h0B};
        send_msg();
        expect_rec("early_rec");
        total++;
        if (short_cnt !== 2'd1 || long_cnt !== 2'd0) begin
            bad++;
            $display("FAIL early_cnt: got %0d/%0d want 1/0", short_cnt, long_cnt);
        end
    endtask

    task automatic test_long();
        msg_q = '{39'h101, 39'h102, 39'h103, 39'h104, 39'h105, 39'h106};
        send_msg();
        total++;
        if (so.valid !== 1'b1) begin
            bad++;
            $display("FAIL long_latency: valid=%0b want 1", so.valid);
        end
        expect_rec("long_rec");
        total++;
        if (long_cnt !== 2'd1 || short_cnt !== 2'd1) begin
            bad++;
            $display("FAIL long_cnt: got long=%0d short=%0d want 1/1", long_cnt, short_cnt);
        end
    endtask

    task automatic test_reset_mid_fill();
        send_word(39'h77, 1'b0);
        send_word(39'h78, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || so.valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state: in_ready=%0b valid=%0b want 1/0", in_ready, so.valid);
        end
        total++;
        if (short_cnt !== 2'd0 || long_cnt !== 2'd0) begin
            bad++;
            $display("FAIL midrst_cnt: got %0d/%0d want 0/0", short_cnt, long_cnt);
        end
        msg_q = '{39'h200, 39'h201, 39'h202, 39'h203};
        send_msg();
        expect_rec("midrst_rec");
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_extra: %0d extra records, want 0", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        msg_q = '{39'h301, 39'h302, 39'h303, 39'h304};
        send_msg();
        msg_q = '{39'h401, 39'h402, 39'h403, 39'h404};
        send_msg();
        expect_rec("b2b_rec0");
        expect_rec("b2b_rec1");
    endtask

    task automatic test_saturation();
        int want;
        for (int i = 0; i < 5; i++) begin
            msg_q = '{39'(i + 500)};
            send_msg();
            expect_rec("sat_rec");
            want = (i + 1 > 3) ? 3 : i + 1;
            total++;
            if (short_cnt !== CW'(want)) begin
                bad++;
                $display("FAIL sat_cnt%0d: got %0d want %0d", i, short_cnt, want);
            end
        end
        total++;
        if (long_cnt !== 2'd0) begin
            bad++;
            $display("FAIL sat_long: got %0d want 0", long_cnt);
        end
    endtask

    initial begin
        so.ready = 1'b1;
        test_reset();
        test_exact();
        test_backpressure();
        test_early_last();
        test_long();
        test_reset_mid_fill();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, want finish");
        $fatal(1);
    end

endmodule
